// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: increment, jump, branch, call, return, run/halt control.
// Latency: a redirect presented in cycle N appears on pc after the edge that ends cycle N. There is no delay slot.
// Backpressure: stall freezes pc, stack and counter. halt_req and start-in-RUN are ignored while stalled.
module pc_fetch_unit #(
  parameter int D        = 10,
  parameter int RS_DEPTH = 4,
  parameter int LAST_PC  = 1023
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stall,
  input  logic [D-1:0] target,
  input  logic         jump_en,
  input  logic         branch_en,
  input  logic         branch_cond,
  input  logic         call_en,
  input  logic         ret_en,
  input  logic         halt_req,
  output logic [D-1:0] pc,
  output logic         running,
  output logic         done,
  output logic         rs_err,
  output logic [15:0]  instr_count
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // The stack pointer needs one extra bit so that it can represent "full" (RS_DEPTH) separately from "empty" (0).
  localparam int IW = $clog2(RS_DEPTH);
  localparam int SPW = IW + 1;
  localparam logic [D-1:0]   LAST    = D'(LAST_PC);
  localparam logic [D-1:0]   PC_ONE  = D'(1);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(RS_DEPTH);
  localparam logic [IW-1:0]  IDX_ONE = IW'(1);

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [D-1:0]   stack_q [RS_DEPTH];

  logic [D-1:0]   pc_inc;
  logic [D-1:0]   nxt_pc;
  logic           seq_sel;
  logic           push_en;
  logic           stk_empty;
  logic           stk_full;
  logic [IW-1:0]  push_idx;
  logic [IW-1:0]  top_idx;

  // pc+1 wraps modulo 2^D. The same value is used as the return address pushed by a call.
  assign pc_inc    = pc_q + PC_ONE;
  assign stk_empty = (sp_q == '0);
  assign stk_full  = (sp_q == SP_FULL);
  assign push_idx  = sp_q[IW-1:0];
  assign top_idx   = push_idx - IDX_ONE;

  // Next-state logic: run/halt control, and next-PC selection by fixed priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sp_d    = sp_q;
    push_en = 1'b0;
    nxt_pc  = pc_inc;
    seq_sel = 1'b0;
    case (state_q)
      S_IDLE: begin
        pc_d = '0;
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          err_d   = 1'b0;
          sp_d    = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (halt_req) begin
            state_d = S_HALTED;
          end else begin
            if (ret_en) begin
              if (!stk_empty) begin
                nxt_pc = stack_q[top_idx];
                sp_d   = sp_q - SP_ONE;
              end else begin
                err_d   = 1'b1;
                seq_sel = 1'b1;
              end
            end else if (call_en) begin
              nxt_pc = target;
              if (!stk_full) begin
                push_en = 1'b1;
                sp_d    = sp_q + SP_ONE;
              end else begin
                err_d = 1'b1;
              end
            end else if (jump_en || (branch_en && branch_cond)) begin
              nxt_pc = target;
            end else begin
              seq_sel = 1'b1;
            end
            // Falling off the end of the program halts instead of wrapping. Redirects taken at LAST_PC are unaffected.
            if (seq_sel && (pc_q == LAST)) state_d = S_HALTED;
            else                           pc_d    = nxt_pc;
          end
        end
      end
      S_HALTED: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          sp_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sp_q    <= sp_d;
    end
  end

  // The return-stack storage has no reset. Entries above the stack pointer are never read.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  assign pc          = pc_q;
  assign running     = (state_q == S_RUN);
  assign done        = (state_q == S_HALTED);
  assign rs_err      = err_q;
  assign instr_count = cnt_q;

endmodule
